// File: rtl/nios_system_sprite_pos_bank.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_sprite_pos_bank
// Brief    : Avalon-MM bank of sprite channels with shadowed X/Y, per-frame
//            velocity advance and offscreen retirement.
// Revision : 1.0
// ============================================================================
module nios_system_sprite_pos_bank #(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 10,
    parameter  int VW       = 8,
    parameter  int XMAX     = 639,
    parameter  int YMAX     = 479,
    localparam int AW       = $clog2(CHANNELS) + 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [AW-1:0]             address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] x_out,
    output logic [CHANNELS*WIDTH-1:0] y_out,
    output logic [CHANNELS-1:0]       active,
    output logic                      offscreen_any
);

    localparam logic signed [WIDTH+1:0] c_xmax = (WIDTH+2)'(XMAX);
    localparam logic signed [WIDTH+1:0] c_ymax = (WIDTH+2)'(YMAX);

    logic                r_fs_d;
    logic                w_tick;
    logic                w_wr;
    logic [AW-1:0]       w_ch_idx;
    logic [31:0]         w_rd [CHANNELS];
    logic [CHANNELS-1:0] w_off;
    logic                w_unused;

    assign w_tick   = frame_sync & ~r_fs_d;
    assign w_wr     = chipselect & ~write_n;
    assign w_ch_idx = address >> 2;
    assign w_unused = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fs_d <= 1'b0;
        else          r_fs_d <= frame_sync;
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0]        r_shx, r_shy, r_lx, r_ly;
        logic [VW-1:0]           r_vx, r_vy;
        logic                    r_en, r_pend, r_off;
        logic signed [WIDTH+1:0] w_nx, w_ny;
        logic                    w_inb, w_sel, w_set_off;

        assign w_sel = w_wr && (w_ch_idx == AW'(n));
        assign w_nx  = $signed({2'b00, r_lx}) + (WIDTH+2)'($signed(r_vx));
        assign w_ny  = $signed({2'b00, r_ly}) + (WIDTH+2)'($signed(r_vy));
        assign w_inb = (w_nx >= 0) && (w_nx <= c_xmax) &&
                       (w_ny >= 0) && (w_ny <= c_ymax);
        assign w_set_off = w_tick && !r_pend && r_en && !w_inb;

        // Later assignments in this block take priority: register writes
        // beat the tick's pending clear and offscreen-induced disable.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_shx  <= '0;
                r_shy  <= '0;
                r_lx   <= '0;
                r_ly   <= '0;
                r_vx   <= '0;
                r_vy   <= '0;
                r_en   <= 1'b0;
                r_pend <= 1'b0;
                r_off  <= 1'b0;
            end else begin
                if (w_tick) begin
                    if (r_pend) begin
                        r_lx   <= r_shx;
                        r_ly   <= r_shy;
                        r_pend <= 1'b0;
                        r_off  <= 1'b0;
                    end else if (r_en && w_inb) begin
                        r_lx <= w_nx[WIDTH-1:0];
                        r_ly <= w_ny[WIDTH-1:0];
                    end else if (r_en) begin
                        r_en  <= 1'b0;
                        r_off <= 1'b1;
                    end
                end
                if (w_sel) begin
                    case (address[1:0])
                        2'd0: begin
                            r_shx  <= writedata[WIDTH-1:0];
                            r_pend <= 1'b1;
                        end
                        2'd1: begin
                            r_shy  <= writedata[WIDTH-1:0];
                            r_pend <= 1'b1;
                        end
                        2'd2: begin
                            r_vx <= writedata[VW-1:0];
                            r_vy <= writedata[VW+15:16];
                        end
                        default: begin
                            r_en <= writedata[0];
                            if (writedata[1] && !w_set_off) r_off <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign x_out[n*WIDTH +: WIDTH] = r_lx;
        assign y_out[n*WIDTH +: WIDTH] = r_ly;
        assign active[n]               = r_en;
        assign w_off[n]                = r_off;

        always_comb begin
            case (address[1:0])
                2'd0:    w_rd[n] = {{(32-WIDTH){1'b0}}, r_lx};
                2'd1:    w_rd[n] = {{(32-WIDTH){1'b0}}, r_ly};
                2'd2:    w_rd[n] = {16'($signed(r_vy)), 16'($signed(r_vx))};
                default: w_rd[n] = {29'd0, r_pend, r_off, r_en};
            endcase
        end
    end

    assign offscreen_any = |w_off;

    always_comb begin
        readdata = 32'd0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (w_ch_idx == AW'(n)) readdata = w_rd[n];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_sprite_pos_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_sprite_pos_bank
// Brief    : Directed vector table plus hand sequences for the sprite bank.
// Revision : 1.0
// ============================================================================
module tb_nios_system_sprite_pos_bank;

    localparam int c_ch = 4;
    localparam int c_w  = 10;

    localparam int OP_WR  = 0;
    localparam int OP_TK  = 1;
    localparam int OP_RD  = 2;
    localparam int OP_X   = 3;
    localparam int OP_Y   = 4;
    localparam int OP_ACT = 5;
    localparam int OP_OFF = 6;

    typedef struct {
        int          op;
        int          arg;
        logic [31:0] val;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [3:0]            address = '0;
    logic                  chipselect = 1'b0;
    logic                  write_n = 1'b1;
    logic [31:0]           writedata = '0;
    logic [31:0]           readdata;
    logic                  frame_sync = 1'b0;
    logic [c_ch*c_w-1:0]   x_out, y_out;
    logic [c_ch-1:0]       active;
    logic                  offscreen_any;

    int errors = 0;
    int checks = 0;
    vec_t v[$];

    nios_system_sprite_pos_bank dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .frame_sync(frame_sync), .x_out(x_out),
        .y_out(y_out), .active(active), .offscreen_any(offscreen_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic add(input int op, input int arg, input logic [31:0] val);
        vec_t e;
        e.op = op; e.arg = arg; e.val = val;
        v.push_back(e);
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        @(negedge clk);
        address = 4'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_tick();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_rd(input int a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        address = 4'(a);
        #1;
        chk(nm, readdata, exp);
    endtask

    function automatic logic [31:0] xo(input int ch);
        return 32'(x_out[ch*c_w +: c_w]);
    endfunction

    function automatic logic [31:0] yo(input int ch);
        return 32'(y_out[ch*c_w +: c_w]);
    endfunction

    initial begin
        // ch1 shadow load and commit
        add(OP_WR, 4, 100); add(OP_WR, 5, 50);
        add(OP_RD, 4, 0);   add(OP_RD, 7, 4);
        add(OP_TK, 0, 0);
        add(OP_X, 1, 100);  add(OP_Y, 1, 50);
        add(OP_RD, 7, 0);   add(OP_RD, 4, 100);
        // ch0 moves right until it leaves the screen
        add(OP_WR, 0, 630); add(OP_WR, 1, 10);
        add(OP_WR, 2, 32'h00FD_0005);
        add(OP_RD, 2, 32'hFFFD_0005);
        add(OP_WR, 3, 1);   add(OP_RD, 3, 5);
        add(OP_TK, 0, 0);
        add(OP_X, 0, 630);  add(OP_Y, 0, 10); add(OP_ACT, 0, 1);
        add(OP_TK, 0, 0);
        add(OP_X, 0, 635);  add(OP_Y, 0, 7);
        add(OP_TK, 0, 0);
        add(OP_X, 0, 635);  add(OP_Y, 0, 7);
        add(OP_ACT, 0, 0);  add(OP_OFF, 0, 1); add(OP_RD, 3, 2);
        add(OP_WR, 3, 2);   add(OP_RD, 3, 0); add(OP_OFF, 0, 0);
        // ch2 underflows on X; ch3 X write with junk upper bits
        add(OP_WR, 8, 3);   add(OP_WR, 9, 3);
        add(OP_WR, 10, 32'h0000_00FC); add(OP_WR, 11, 1);
        add(OP_WR, 12, 32'hABCD_0064); add(OP_RD, 12, 0);
        add(OP_TK, 0, 0);
        add(OP_X, 2, 3);    add(OP_ACT, 0, 4); add(OP_X, 3, 100);
        add(OP_TK, 0, 0);
        add(OP_X, 2, 3);    add(OP_Y, 2, 3);
        add(OP_ACT, 0, 0);  add(OP_OFF, 0, 1); add(OP_RD, 11, 2);
        add(OP_WR, 11, 2);  add(OP_OFF, 0, 0);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset x_out", 32'(x_out), 0);
        chk("reset y_out", 32'(y_out), 0);
        chk("reset active", 32'(active), 0);
        chk("reset offscreen_any", 32'(offscreen_any), 0);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) chk_rd(a, 0, $sformatf("reset rd[%0d]", a));

        for (int i = 0; i < v.size(); i++) begin
            case (v[i].op)
                OP_WR: do_write(v[i].arg, v[i].val);
                OP_TK: do_tick();
                OP_RD: chk_rd(v[i].arg, v[i].val, $sformatf("vec%0d rd[%0d]", i, v[i].arg));
                OP_X: begin
                    @(negedge clk);
                    chk($sformatf("vec%0d x[%0d]", i, v[i].arg), xo(v[i].arg), v[i].val);
                end
                OP_Y: begin
                    @(negedge clk);
                    chk($sformatf("vec%0d y[%0d]", i, v[i].arg), yo(v[i].arg), v[i].val);
                end
                OP_ACT: begin
                    @(negedge clk);
                    chk($sformatf("vec%0d active", i), 32'(active), v[i].val);
                end
                default: begin
                    @(negedge clk);
                    chk($sformatf("vec%0d offscreen_any", i), 32'(offscreen_any), v[i].val);
                end
            endcase
        end

        // X write on the tick edge: old shadow commits, new stays pending
        do_write(12, 200);
        @(negedge clk);
        frame_sync = 1'b1;
        address = 4'd12; writedata = 300; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; frame_sync = 1'b0;
        @(negedge clk);
        chk("coincident commit x[3]", xo(3), 200);
        chk_rd(15, 4, "coincident pending");
        do_tick();
        chk("second commit x[3]", xo(3), 300);
        chk_rd(15, 0, "second commit pending");

        // held frame_sync yields a single tick
        do_write(6, 1);
        do_write(7, 1);
        do_tick();
        chk("ch1 step x", xo(1), 101);
        @(negedge clk);
        frame_sync = 1'b1;
        repeat (4) @(negedge clk);
        chk("held sync one tick x", xo(1), 102);

        // async reset mid-motion with frame_sync still high
        #2 reset_n = 1'b0;
        #1;
        chk("async reset x_out", 32'(x_out[31:0]), 0);
        chk("async reset x_out hi", 32'(x_out[39:32]), 0);
        chk("async reset active", 32'(active), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset x[1]", xo(1), 0);
        chk("post reset y[1]", yo(1), 0);
        chk("post reset x[3]", xo(3), 0);
        chk("post reset active", 32'(active), 0);
        chk("post reset offscreen_any", 32'(offscreen_any), 0);
        chk_rd(7, 0, "post reset ctrl ch1");
        frame_sync = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
